// File: rtl/fft_frame_ctrl_if.sv
`timescale 1ns/1ps
// Purpose: sample-source and stage-chain signals of the R2SDF FFT front-end sequencer.
// Latency: none; this is wiring only, and all timing lives in fft_frame_ctrl.
// Backpressure: oReady qualifies iValid, and the chain advances only when oPipe_en is high.
// Ports (signals):
//   iValid, iData_Re, iData_Im, oReady         source -> controller valid/ready bus
//   oPipe_en, oPipe_valid, oPipe_Re, oPipe_Im   controller -> stage 1
//   iPipe_valid                                last stage -> controller output tracker
// Modports: slave = controller view, master = environment (source + stage chain) view.
interface fft_frame_ctrl_if #(
    parameter int DW = 16
);
    logic          iValid;
    logic [DW-1:0] iData_Re;
    logic [DW-1:0] iData_Im;
    logic          oReady;
    logic          oPipe_en;
    logic          oPipe_valid;
    logic [DW-1:0] oPipe_Re;
    logic [DW-1:0] oPipe_Im;
    logic          iPipe_valid;

    modport slave (
        input  iValid, iData_Re, iData_Im, iPipe_valid,
        output oReady, oPipe_en, oPipe_valid, oPipe_Re, oPipe_Im
    );

    modport master (
        output iValid, iData_Re, iData_Im, iPipe_valid,
        input  oReady, oPipe_en, oPipe_valid, oPipe_Re, oPipe_Im
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
`timescale 1ns/1ps
// Purpose: front-end sequencer for the R2SDF FFT chain: loads frames, flushes the delay lines, and tracks output frames.
// Latency: an accepted sample appears on oPipe_* 1 cycle later; oOut_sop/eop/idx are combinational with iPipe_valid.
// Backpressure: oReady is high in IDLE/LOAD and low in FLUSH; with no transfer in LOAD the chain is stalled (oPipe_en=0).
// Ports:
//   iClk, Rst            clock (rising edge), asynchronous active-high reset
//   bus (slave)          iValid/iData_Re/iData_Im/oReady source side; oPipe_* to stage 1; iPipe_valid from last stage
//   oOut_idx             index of the current chain output (bit-reversed when FFT_CTRL_BITREV_EN is defined)
//   oOut_sop, oOut_eop   first / last output of a frame
//   oBusy                FSM not IDLE
//   oFrame_cnt           completed output frames (wraps)
//   oFlush_err           sticky flush watchdog expiry, cleared only by Rst
// Build option: define FFT_CTRL_BITREV_EN to report natural-order bin indices on oOut_idx.
module fft_frame_ctrl #(
    parameter int LOG2N    = 8,
    parameter int DW       = 16,
    parameter int FLUSH_MX = 512
) (
    input  logic             iClk,
    input  logic             Rst,
    fft_frame_ctrl_if.slave  bus,
    output logic [LOG2N-1:0] oOut_idx,
    output logic             oOut_sop,
    output logic             oOut_eop,
    output logic             oBusy,
    output logic [15:0]      oFrame_cnt,
    output logic             oFlush_err
);
    localparam int FW = $clog2(FLUSH_MX) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [LOG2N-1:0] r_in_cnt;
    logic [FW-1:0]    r_flush_cnt;
    logic [7:0]       r_frm_issued;
    logic [7:0]       r_frm_done;
    logic [LOG2N-1:0] r_out_idx;
    logic [15:0]      r_frame_cnt;
    logic             r_flush_err;
    logic             r_pipe_en;
    logic             r_pipe_valid;
    logic [DW-1:0]    r_pipe_re;
    logic [DW-1:0]    r_pipe_im;

    logic w_ready;
    logic w_xfer;
    logic w_last_in;
    logic w_sop;
    logic w_eop;
    logic w_out_done;
    logic w_wdog;

    assign w_ready   = (r_state != S_FLUSH);
    assign w_xfer    = bus.iValid & w_ready;
    // The last sample of an input frame is being accepted this cycle.
    assign w_last_in = (r_state == S_LOAD) && w_xfer && (r_in_cnt == '1);

    assign w_sop      = bus.iPipe_valid && (r_out_idx == '0);
    assign w_eop      = bus.iPipe_valid && (r_out_idx == '1);
    // This eop closes the last issued frame, so the chain is fully drained.
    assign w_out_done = w_eop && ((r_frm_done + 8'd1) == r_frm_issued);
    assign w_wdog     = (r_state == S_FLUSH) && (r_flush_cnt == FW'(FLUSH_MX - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer) w_state_nxt = S_LOAD;
            // in_cnt is 0 in LOAD only on the cycle after a frame completed.
            S_LOAD:  if ((r_in_cnt == '0) && !w_xfer) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_out_done || w_wdog) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge Rst) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_in_cnt     <= '0;
            r_flush_cnt  <= '0;
            r_frm_issued <= '0;
            r_frm_done   <= '0;
            r_out_idx    <= '0;
            r_frame_cnt  <= '0;
            r_flush_err  <= 1'b0;
            r_pipe_en    <= 1'b0;
            r_pipe_valid <= 1'b0;
            r_pipe_re    <= '0;
            r_pipe_im    <= '0;
        end else begin
            r_state <= w_state_nxt;

            // in_cnt is always 0 in IDLE, so the first accept in IDLE yields 1 as well.
            if (w_xfer) r_in_cnt <= r_in_cnt + 1'b1;

            if (r_state == S_FLUSH) r_flush_cnt <= r_flush_cnt + 1'b1;
            else                    r_flush_cnt <= '0;

            if (w_last_in) r_frm_issued <= r_frm_issued + 8'd1;

            // On watchdog expiry, outstanding frames are abandoned. The counters are
            // realigned so that the next flush can still detect its own final eop.
            if (w_wdog)     r_frm_done <= r_frm_issued;
            else if (w_eop) r_frm_done <= r_frm_done + 8'd1;

            if (w_wdog) r_flush_err <= 1'b1;

            if (bus.iPipe_valid) r_out_idx   <= r_out_idx + 1'b1;
            if (w_eop)           r_frame_cnt <= r_frame_cnt + 16'd1;

            // FLUSH clocks zeros through the chain so the delay buffers drain.
            r_pipe_en    <= w_xfer || (r_state == S_FLUSH);
            r_pipe_valid <= w_xfer;
            r_pipe_re    <= w_xfer ? bus.iData_Re : '0;
            r_pipe_im    <= w_xfer ? bus.iData_Im : '0;
        end
    end

    assign bus.oReady      = w_ready;
    assign bus.oPipe_en    = r_pipe_en;
    assign bus.oPipe_valid = r_pipe_valid;
    assign bus.oPipe_Re    = r_pipe_re;
    assign bus.oPipe_Im    = r_pipe_im;

    assign oOut_sop   = w_sop;
    assign oOut_eop   = w_eop;
    assign oBusy      = (r_state != S_IDLE);
    assign oFrame_cnt = r_frame_cnt;
    assign oFlush_err = r_flush_err;

`ifdef FFT_CTRL_BITREV_EN
    // R2SDF emits bins in bit-reversed order; reversing the arrival index gives the natural bin.
    genvar g;
    for (g = 0; g < LOG2N; g++) begin : g_rev
        assign oOut_idx[g] = r_out_idx[LOG2N-1-g];
    end
`else
    assign oOut_idx = r_out_idx;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
`timescale 1ns/1ps
module tb_fft_frame_ctrl;
    localparam int LOG2N    = 8;
    localparam int DW       = 16;
    localparam int FLUSH_MX = 512;
    localparam int NPTS     = 256;
    localparam int LAT      = 20;   // latency of the behavioural stage-chain model, in enabled cycles

    logic iClk = 1'b0;
    logic Rst;
    always #5 iClk = ~iClk;

    fft_frame_ctrl_if #(.DW(DW)) bus();

    logic [LOG2N-1:0] oOut_idx;
    logic             oOut_sop;
    logic             oOut_eop;
    logic             oBusy;
    logic [15:0]      oFrame_cnt;
    logic             oFlush_err;

    fft_frame_ctrl #(.LOG2N(LOG2N), .DW(DW), .FLUSH_MX(FLUSH_MX)) dut (
        .iClk       (iClk),
        .Rst        (Rst),
        .bus        (bus),
        .oOut_idx   (oOut_idx),
        .oOut_sop   (oOut_sop),
        .oOut_eop   (oOut_eop),
        .oBusy      (oBusy),
        .oFrame_cnt (oFrame_cnt),
        .oFlush_err (oFlush_err)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_fc;

    // Stage-chain model: a delay line that advances only when oPipe_en is high.
    logic           chain_on;
    logic           chain_v;
    logic           man_v;
    logic [LAT-1:0] dl;
    assign bus.iPipe_valid = chain_on ? chain_v : man_v;

    always @(posedge iClk or posedge Rst) begin
        if (Rst) begin
            dl      = '0;
            chain_v = 1'b0;
        end else begin
            #1;
            chain_v = chain_on && bus.oPipe_en && dl[LAT-1];
            if (bus.oPipe_en) dl = {dl[LAT-2:0], bus.oPipe_valid};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = v[7-b];
        return r;
    endfunction

    task automatic check_idle(input string nm);
        chk({nm, "_pipe_en"},    32'(bus.oPipe_en),    32'd0);
        chk({nm, "_pipe_valid"}, 32'(bus.oPipe_valid), 32'd0);
        chk({nm, "_pipe_re"},    32'(bus.oPipe_Re),    32'd0);
        chk({nm, "_pipe_im"},    32'(bus.oPipe_Im),    32'd0);
        chk({nm, "_sop"},        32'(oOut_sop),        32'd0);
        chk({nm, "_eop"},        32'(oOut_eop),        32'd0);
        chk({nm, "_idx"},        32'(oOut_idx),        32'd0);
        chk({nm, "_busy"},       32'(oBusy),           32'd0);
        chk({nm, "_frame_cnt"},  32'(oFrame_cnt),      32'd0);
        chk({nm, "_flush_err"},  32'(oFlush_err),      32'd0);
        chk({nm, "_ready"},      32'(bus.oReady),      32'd1);
    endtask

    typedef struct {
        int frames;      // contiguous frames to load
        int gap;         // iValid low when cycle % gap == gap-1 (0 = no gaps)
        int exp_exit;    // drain cycle (1 = cycle after the last accept) on which oBusy must be 0
        int exp_fc_inc;  // expected oFrame_cnt increase
        int exp_err;     // expected oFlush_err after the drain
        int chain;       // 1 = chain model returns iPipe_valid, 0 = chain is silent
    } scen_t;

    scen_t tbl [5];

    task automatic run_scen(input int id, input scen_t s);
        int          total = s.frames * NPTS;
        int          sent  = 0;
        int          cyc   = 0;
        logic        pv    = 1'b0;
        logic [15:0] pre   = '0;
        logic [15:0] pim   = '0;
        chain_on = (s.chain != 0);
        while (sent < total) begin
            @(negedge iClk);
            chk($sformatf("s%0d_pipe_en", id),    32'(bus.oPipe_en),    32'(pv));
            chk($sformatf("s%0d_pipe_valid", id), 32'(bus.oPipe_valid), 32'(pv));
            if (pv) begin
                chk($sformatf("s%0d_pipe_re", id), 32'(bus.oPipe_Re), 32'(pre));
                chk($sformatf("s%0d_pipe_im", id), 32'(bus.oPipe_Im), 32'(pim));
            end
            chk($sformatf("s%0d_busy", id),  32'(oBusy),      32'(sent > 0));
            chk($sformatf("s%0d_ready", id), 32'(bus.oReady), 32'd1);
            if (s.gap != 0 && (cyc % s.gap) == s.gap - 1) begin
                bus.iValid = 1'b0;
                pv = 1'b0;
            end else begin
                bus.iValid   = 1'b1;
                pre          = 16'(sent);
                pim          = 16'(-sent);
                bus.iData_Re = pre;
                bus.iData_Im = pim;
                sent++;
                pv = 1'b1;
            end
            cyc++;
        end
        for (int k = 1; k <= s.exp_exit; k++) begin
            @(negedge iClk);
            if (k == 1) begin
                bus.iValid   = 1'b0;
                bus.iData_Re = 16'h5A5A;
                bus.iData_Im = 16'hA5A5;
                chk($sformatf("s%0d_last_en", id),    32'(bus.oPipe_en),    32'd1);
                chk($sformatf("s%0d_last_valid", id), 32'(bus.oPipe_valid), 32'd1);
                chk($sformatf("s%0d_last_re", id),    32'(bus.oPipe_Re),    32'(pre));
                chk($sformatf("s%0d_last_im", id),    32'(bus.oPipe_Im),    32'(pim));
            end else if (k == 2) begin
                chk($sformatf("s%0d_fl0_ready", id), 32'(bus.oReady),      32'd0);
                chk($sformatf("s%0d_fl0_en", id),    32'(bus.oPipe_en),    32'd0);
                chk($sformatf("s%0d_fl0_valid", id), 32'(bus.oPipe_valid), 32'd0);
            end else if (k < s.exp_exit) begin
                chk($sformatf("s%0d_fl_ready", id), 32'(bus.oReady),      32'd0);
                chk($sformatf("s%0d_fl_en", id),    32'(bus.oPipe_en),    32'd1);
                chk($sformatf("s%0d_fl_valid", id), 32'(bus.oPipe_valid), 32'd0);
                chk($sformatf("s%0d_fl_re", id),    32'(bus.oPipe_Re),    32'd0);
                chk($sformatf("s%0d_fl_im", id),    32'(bus.oPipe_Im),    32'd0);
                chk($sformatf("s%0d_fl_busy", id),  32'(oBusy),           32'd1);
            end else begin
                exp_fc = exp_fc + 16'(s.exp_fc_inc);
                chk($sformatf("s%0d_exit_busy", id),  32'(oBusy),       32'd0);
                chk($sformatf("s%0d_exit_ready", id), 32'(bus.oReady),  32'd1);
                chk($sformatf("s%0d_frame_cnt", id),  32'(oFrame_cnt),  32'(exp_fc));
                chk($sformatf("s%0d_flush_err", id),  32'(oFlush_err),  32'(s.exp_err));
            end
        end
        bus.iData_Re = '0;
        bus.iData_Im = '0;
    endtask

    initial begin
        Rst          = 1'b1;
        bus.iValid   = 1'b0;
        bus.iData_Re = '0;
        bus.iData_Im = '0;
        man_v        = 1'b0;
        chain_on     = 1'b1;
        exp_fc       = '0;

        tbl[0] = '{frames: 1, gap: 0, exp_exit: LAT + 3,      exp_fc_inc: 1, exp_err: 0, chain: 1};
        tbl[1] = '{frames: 1, gap: 3, exp_exit: LAT + 3,      exp_fc_inc: 1, exp_err: 0, chain: 1};
        tbl[2] = '{frames: 2, gap: 0, exp_exit: LAT + 3,      exp_fc_inc: 2, exp_err: 0, chain: 1};
        tbl[3] = '{frames: 1, gap: 7, exp_exit: LAT + 3,      exp_fc_inc: 1, exp_err: 0, chain: 1};
        tbl[4] = '{frames: 1, gap: 0, exp_exit: FLUSH_MX + 2, exp_fc_inc: 0, exp_err: 1, chain: 0};

        repeat (3) @(posedge iClk);
        @(negedge iClk);
        Rst = 1'b0;

        // Reset in the middle of a frame: 37 samples accepted, then Rst for 3 cycles.
        for (int i = 0; i < 37; i++) begin
            @(negedge iClk);
            bus.iValid   = 1'b1;
            bus.iData_Re = 16'(i + 1);
            bus.iData_Im = 16'(i + 1);
        end
        @(negedge iClk);
        chk("midload_busy", 32'(oBusy), 32'd1);
        bus.iValid   = 1'b0;
        bus.iData_Re = '0;
        bus.iData_Im = '0;
        Rst = 1'b1;
        repeat (3) begin
            @(posedge iClk);
            #1;
            check_idle("in_rst");
        end
        @(negedge iClk);
        Rst = 1'b0;
        @(negedge iClk);
        check_idle("post_rst");

        for (int t = 0; t < 5; t++) run_scen(t, tbl[t]);

        // Output tracker driven directly, with a one-cycle hole at step 100.
        chain_on = 1'b0;
        begin
            int         idx = 0;
            logic [7:0] e;
            for (int st = 0; st <= NPTS; st++) begin
                @(negedge iClk);
                man_v = (st != 100);
                #1;
                e = 8'(idx);
`ifdef FFT_CTRL_BITREV_EN
                e = rev8(e);
`endif
                chk("trk_idx", 32'(oOut_idx), 32'(e));
                chk("trk_sop", 32'(oOut_sop), 32'(man_v && idx == 0));
                chk("trk_eop", 32'(oOut_eop), 32'(man_v && idx == NPTS - 1));
                if (man_v) idx++;
            end
            @(negedge iClk);
            man_v  = 1'b0;
            exp_fc = exp_fc + 16'd1;
            chk("trk_frame_cnt", 32'(oFrame_cnt), 32'(exp_fc));
            #1;
            chk("trk_idx_wrap", 32'(oOut_idx), 32'd0);
        end

        // The sticky watchdog flag is cleared only by reset.
        @(negedge iClk);
        Rst = 1'b1;
        @(negedge iClk);
        Rst = 1'b0;
        @(negedge iClk);
        check_idle("final_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
